// File: rtl/tran_pkg.sv
// Shared types for the tran bus arbiter: FSM state encoding and the requester ceiling.
package tran_pkg;
  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;
endpackage

// File: rtl/tran_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above i_ptr, wrapping past the top index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);
  logic [2*N-1:0] w_dbl;

  // Rotating a doubled copy puts the pointer's requester at bit 0, so wrap is free.
  assign w_dbl = {i_req, i_req} >> i_ptr;

  always_comb begin
    int v_off;
    int v_sum;
    o_valid = 1'b0;
    v_off   = 0;
    v_sum   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_dbl[i]) begin
        o_valid = 1'b1;
        v_off   = i;
      end
    end
    v_sum = int'(i_ptr) + v_off;
    if (v_sum >= N) v_sum = v_sum - N;
    o_idx = IW'(v_sum);
  end
endmodule

// File: rtl/tran_bus_arbiter.sv
// Single-owner arbiter for a tran-segmented shared net: one tristate enable at a time,
// fixed all-off turnaround between owners, keeper enabled whenever nobody drives.
module tran_bus_arbiter
  import tran_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         drv_en,
  output logic                    keeper_en,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output state_t                  dbg_state
);
  localparam int IW = $clog2(NREQ);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = $clog2(TURN_CYC + 1);

  if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("tran_bus_arbiter: NREQ must be 2..8");
  end
  if (TURN_CYC < 1 || TURN_CYC > 15) begin : g_bad_turn
    $error("tran_bus_arbiter: TURN_CYC must be 1..15");
  end
  if (MAX_HOLD < 0) begin : g_bad_hold
    $error("tran_bus_arbiter: MAX_HOLD must be >= 0");
  end

  state_t          r_state, w_state;
  logic [IW-1:0]   r_owner, w_owner;
  logic [IW-1:0]   r_ptr, w_ptr;
  logic [HW-1:0]   r_hold, w_hold;
  logic [TW-1:0]   r_turn, w_turn;
  logic [NREQ-1:0] r_gnt, w_gnt;
  logic            r_keeper, r_busy;
  logic            w_pick_valid, w_grant_go, w_own_req, w_others;
  logic [IW-1:0]   w_pick_idx;
  logic [NREQ-1:0] w_own_mask;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_own_mask = NREQ'(1) << r_owner;
  assign w_own_req  = |(req & w_own_mask);
  assign w_others   = |(req & ~w_own_mask);

  // Handshake: a requester holds req high until done; it may drive the net only while
  // its gnt bit is high, and dropping req ends its tenure at the next edge.
  always_comb begin
    w_state    = r_state;
    w_owner    = r_owner;
    w_ptr      = r_ptr;
    w_hold     = r_hold;
    w_turn     = r_turn;
    w_grant_go = 1'b0;
    case (r_state)
      IDLE: w_grant_go = w_pick_valid;
      GRANT: begin
        if (MAX_HOLD != 0 && r_hold != HW'(MAX_HOLD)) w_hold = r_hold + 1'b1;
        if (!w_own_req || (MAX_HOLD != 0 && w_hold == HW'(MAX_HOLD) && w_others)) begin
          w_state = TURN;
          w_turn  = '0;
        end
      end
      TURN: begin
        if (r_turn == TW'(TURN_CYC - 1)) begin
          if (w_pick_valid) w_grant_go = 1'b1;
          else              w_state    = IDLE;
        end else begin
          w_turn = r_turn + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
    // Pointer moves past the winner so a force-released owner drops to lowest priority.
    if (w_grant_go) begin
      w_state = GRANT;
      w_owner = w_pick_idx;
      w_ptr   = (w_pick_idx == IW'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
      w_hold  = '0;
    end
    w_gnt = (w_state == GRANT) ? (NREQ'(1) << w_owner) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_hold   <= '0;
      r_turn   <= '0;
      r_gnt    <= '0;
      r_keeper <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_owner  <= w_owner;
      r_ptr    <= w_ptr;
      r_hold   <= w_hold;
      r_turn   <= w_turn;
      r_gnt    <= w_gnt;
      r_keeper <= ~|w_gnt;
      r_busy   <= (w_state != IDLE);
    end
  end

  assign gnt       = r_gnt;
  assign drv_en    = r_gnt;
  assign keeper_en = r_keeper;
  assign owner     = r_owner;
  assign busy      = r_busy;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_tran_bus_arbiter.sv
// Bench for tran_bus_arbiter: ownership model feeds an expected queue checked each cycle.
module tb_tran_bus_arbiter;
  import tran_pkg::*;

  localparam int NREQ     = 4;
  localparam int TURN_CYC = 2;
  localparam int MAX_HOLD = 4;
  localparam int IW       = 2;
  localparam int W        = 2 * NREQ + IW + 2;

  logic            clk, rst_n;
  logic [NREQ-1:0] req, gnt, drv_en;
  logic [NREQ-1:0] req_unl, gnt_unl, drv_en_unl;
  logic            keeper_en, busy, keeper_unl, busy_unl;
  logic [IW-1:0]   owner, owner_unl;
  state_t          dbg_state, dbg_unl;

  logic [W-1:0] exp_q[$];
  int n_total, n_bad;
  bit model_on;

  // Reference model: phase 0 = nobody owns, 1 = owned, 2 = turnaround gap.
  int m_phase, m_owner, m_ptr, m_hold, m_gap;

  tran_bus_arbiter #(.NREQ(NREQ), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .drv_en(drv_en),
    .keeper_en(keeper_en), .owner(owner), .busy(busy), .dbg_state(dbg_state)
  );

  tran_bus_arbiter #(.NREQ(NREQ), .TURN_CYC(TURN_CYC), .MAX_HOLD(0)) u_unl (
    .clk(clk), .rst_n(rst_n), .req(req_unl), .gnt(gnt_unl), .drv_en(drv_en_unl),
    .keeper_en(keeper_unl), .owner(owner_unl), .busy(busy_unl), .dbg_state(dbg_unl)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int from);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (from + k) % NREQ;
      if (r[IW'(j)]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_gap = 0;
  endtask

  task automatic model_take(input int w);
    m_phase = 1;
    m_owner = w;
    m_ptr   = (w + 1) % NREQ;
    m_hold  = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r);
    int w;
    case (m_phase)
      0: begin
        w = pick(r, m_ptr);
        if (w >= 0) model_take(w);
      end
      1: begin
        m_hold++;
        if (!r[IW'(m_owner)] ||
            (MAX_HOLD != 0 && m_hold >= MAX_HOLD && (r & ~(NREQ'(1) << m_owner)) != '0)) begin
          m_phase = 2;
          m_gap   = 0;
        end
      end
      default: begin
        m_gap++;
        if (m_gap == TURN_CYC) begin
          w = pick(r, m_ptr);
          if (w >= 0) model_take(w);
          else        m_phase = 0;
        end
      end
    endcase
  endtask

  function automatic logic [W-1:0] model_out();
    logic [NREQ-1:0] g;
    g = (m_phase == 1) ? (NREQ'(1) << m_owner) : '0;
    return {g, g, 1'(m_phase != 1), IW'(m_owner), 1'(m_phase != 0)};
  endfunction

  // scoreboard producer: model sees the same sampled req as the DUT
  always @(posedge clk) begin
    if (rst_n && model_on) begin
      model_step(req);
      exp_q.push_back(model_out());
    end
  end

  // scoreboard consumer
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", 32'({drv_en, gnt, keeper_en, owner, busy}), 32'(e));
      check("drv_onehot0", 32'($onehot0(drv_en)), 32'd1);
    end
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic hold_req(input logic [NREQ-1:0] v, input int cyc);
    req = v;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic release_after_three(input int cyc);
    int cnt[NREQ];
    for (int i = 0; i < NREQ; i++) cnt[IW'(i)] = 0;
    req = '1;
    repeat (cyc) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[IW'(i)]) cnt[IW'(i)]++;
        else             cnt[IW'(i)] = 0;
        req[IW'(i)] = (cnt[IW'(i)] < 3);
      end
    end
  endtask

  task automatic random_req(input int cyc);
    repeat (cyc) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 4) == 0) req[IW'(i)] = ~req[IW'(i)];
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t;
    n_total = 0; n_bad = 0; model_on = 0;
    req = '0; req_unl = '0; rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_drv_en", 32'(drv_en), 32'd0);
    check("rst_keeper", 32'(keeper_en), 32'd1);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_on = 1;

    // single requester, then two-way handover
    hold_req(4'b0000, 4);
    hold_req(4'b0001, 5);
    hold_req(4'b0000, 5);
    hold_req(4'b0011, 6);
    hold_req(4'b0010, 8);
    hold_req(4'b0000, 6);

    // everyone requesting, each owner lets go after three cycles
    release_after_three(40);
    hold_req(4'b0000, 6);

    // constant contention: forced release here, indefinite hold with MAX_HOLD = 0
    req = 4'b0011;
    req_unl = 4'b0011;
    @(posedge clk);
    repeat (40) begin
      @(negedge clk);
      check("unl_hold", 32'(gnt_unl), 32'b0001);
    end
    @(posedge clk);
    #1;
    req_unl = '0;
    hold_req(4'b0000, 6);

    random_req(400);

    // asynchronous reset while someone owns the net
    req = 4'b0110;
    t = 0;
    while (gnt == '0 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("grant_before_reset", 32'(gnt != '0), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_on = 0;
    exp_q.delete();
    #1;
    check("async_drv_en", 32'(drv_en), 32'd0);
    check("async_keeper", 32'(keeper_en), 32'd1);
    check("async_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    model_on = 1;
    @(posedge clk);
    #1;
    check("post_reset_first_gnt", 32'(gnt), 32'b0010);
    hold_req(4'b0110, 10);
    hold_req(4'b0000, 8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
